decode_imm_stage: RTL and testbench
===================================

Name: decode_imm_stage

Overview:
Decode-stage front end that classifies each fetched RV64 instruction by opcode, selects the `immediate_type_e` for it, and drives an `immediate_generator` instance. Results (instr, pc, immediate, type, illegal flag) are held in a 2-entry registered buffer with valid/ready handshakes on both sides. It sits between the fetch stage and the register-read/execute control. It decouples back-pressure so `in_ready_o` is a pure register output.

Parameters:
- DATA_WIDTH, 64 (`` `DATA_WIDTH ``), width of the pc and immediate.
- INSTR_WIDTH, 32 (`` `INSTR_WIDTH ``), instruction width.
- DEPTH, 2 (fixed), buffer entries; only 2 is supported.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered entries and any same-cycle input.
- in_valid_i  in  1  fetch offers an instruction.
- in_ready_o  out  1  stage can accept; registered.
- in_instr_i  in  INSTR_WIDTH  instruction word.
- in_pc_i  in  DATA_WIDTH  instruction address.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head.
- out_instr_o  out  INSTR_WIDTH  head instruction.
- out_pc_o  out  DATA_WIDTH  head pc.
- out_imm_o  out  DATA_WIDTH  head sign-extended immediate.
- out_imm_type_o  out  immediate_type_e  head immediate type.
- out_illegal_o  out  1  head opcode/encoding unsupported.

Interface decision: one clock `clk_i`; reset `rst_i` is synchronous and active-high.

Behaviour:
- Type select is decoded combinationally from `in_instr_i[6:0]`:
  - LUI 0110111, AUIPC 0010111 -> U.
  - JAL 1101111 -> J.
  - JALR 1100111, LOAD 0000011, MISC-MEM 0001111, SYSTEM 1110011 -> I.
  - STORE 0100011 -> S.
  - BRANCH 1100011 -> B.
  - OP-IMM 0010011: funct3 001/101 -> ISHIFT, else I.
  - OP-IMM-32 0011011: funct3 001/101 -> ISHIFT, else I.
  - OP 0110011, OP-32 0111011 -> NONE.
  - Any other opcode -> NONE with illegal=1.
- OP-IMM-32 shift with `instr[25]=1` -> illegal=1, type NONE.
- When illegal=1, the stored immediate is 0.
- Immediate is computed at input time and stored with the entry. It is never recomputed at output.
- Push: `in_valid_i && in_ready_o && !flush_i`. Pop: `out_valid_o && out_ready_i`.
- Storage is a 2-entry circular buffer with wr_ptr, rd_ptr (1 bit each) and count (0..2).
- `in_ready_o` = (count != 2), from registered state only.
- `out_valid_o` = (count != 0). Outputs reflect the rd_ptr entry.
- Latency: accepted in cycle N -> visible at `out_*` in cycle N+1 if the buffer was empty. No combinational in->out path.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - At count 2, push cannot occur; pop alone -> count 1, `in_ready_o`=1 next cycle.
- `flush_i`:
  - count, wr_ptr and rd_ptr -> 0 next cycle.
  - Same-cycle push is ignored.
  - Same-cycle pop handshake is still legal; the consumer may take the head.
  - Flush has priority over push/pop in all state updates.
- Reset: count=0, pointers=0, all storage cleared to 0.
  - Outputs after reset: `out_valid_o`=0, `in_ready_o`=1, `out_instr_o`=0, `out_pc_o`=0, `out_imm_o`=0, `out_imm_type_o`=IMM_TYPE_NONE, `out_illegal_o`=0.
  - Reset mid-stream drops all entries.
- Data outputs are held stable while `out_valid_o && !out_ready_i`.

Decomposition:
- Opcode constants (OPC_LUI…OPC_SYSTEM) and funct3 shift codes go in a shared RISC-V opcode package/header next to `defines.svh`.
- `immediate_type_e` stays in `immediate_types.svh`.
- One sub-module: an `immediate_generator` instance fed by `in_instr_i` and the decoded type.
- The decode function stays inline (an `always_comb` case).

Test Plan:
1. Reset, then push 0xFFF00093 (ADDI x1,x0,-1) with pc 0x1000 and `out_ready_i`=1 -> next cycle `out_valid_o`=1, type I, imm 0xFFFFFFFFFFFFFFFF, pc 0x1000.
2. Push 0x12345037 then 0x80000037 (LUI) -> imm 0x0000000012345000, then 0xFFFFFFFF80000000, both type U, in order.
3. Push 0xFE000EE3 (BEQ -4) and 0x03F09093 (SLLI x1,x1,63) -> B / 0xFFFFFFFFFFFFFFFC, then ISHIFT / 63.
4. Push 0x0000007F and 0x0200109B -> both illegal=1, type NONE, imm 0.
5. Hold `out_ready_i`=0 and offer 3 instructions back-to-back:
   - `in_ready_o` drops after 2 accepts; the third is held by fetch.
   - Release `out_ready_i` -> order A, B, C preserved.
   - `in_ready_o` reasserts the cycle after the first pop.
6. Buffer full, assert `flush_i` with `in_valid_i`=1 -> next cycle `out_valid_o`=0, `in_ready_o`=1, the flushed-cycle instruction never appears. Assert `rst_i` mid-stream -> same empty state.

Source files
------------

// File: rtl/decode_imm_stage_pkg.sv
// Shared RV64 decode definitions: widths, opcode/funct3 codes, immediate
// types and the buffered entry layout used by the decode-immediate stage.
package decode_imm_stage_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int DEPTH       = 2;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // NONE must stay at zero so a cleared entry reads back as "no immediate".
    typedef enum logic [2:0] {
        IMM_TYPE_NONE   = 3'd0,
        IMM_TYPE_I      = 3'd1,
        IMM_TYPE_ISHIFT = 3'd2,
        IMM_TYPE_S      = 3'd3,
        IMM_TYPE_B      = 3'd4,
        IMM_TYPE_U      = 3'd5,
        IMM_TYPE_J      = 3'd6
    } immediate_type_e;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  imm;
        immediate_type_e        imm_type;
        logic                   illegal;
    } buf_entry_t;

    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    endfunction

endpackage

// File: rtl/decode_imm_stage_if.sv
// Fetch-side and consumer-side handshake bundle of the decode-immediate stage.
interface decode_imm_stage_if
    import decode_imm_stage_pkg::*;
();
    logic                   flush_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [INSTR_WIDTH-1:0] in_instr_i;
    logic [DATA_WIDTH-1:0]  in_pc_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [INSTR_WIDTH-1:0] out_instr_o;
    logic [DATA_WIDTH-1:0]  out_pc_o;
    logic [DATA_WIDTH-1:0]  out_imm_o;
    immediate_type_e        out_imm_type_o;
    logic                   out_illegal_o;

    modport master (
        output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_imm_o,
               out_imm_type_o, out_illegal_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_imm_o,
               out_imm_type_o, out_illegal_o
    );
endinterface

// File: rtl/decode_imm_stage_immediate_generator.sv
// Builds the sign-extended RV64 immediate for a given immediate type.
// Only instruction bits [31:7] carry immediate fields, so the opcode is not an input.
module immediate_generator
    import decode_imm_stage_pkg::*;
(
    input  logic [INSTR_WIDTH-1:7] instr,
    input  immediate_type_e        imm_type,
    output logic [DATA_WIDTH-1:0]  imm
);

    always_comb begin
        imm = '0;
        unique case (imm_type)
            IMM_TYPE_I:      imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            IMM_TYPE_ISHIFT: imm = {{(DATA_WIDTH-6){1'b0}}, instr[25:20]};
            IMM_TYPE_S:      imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_TYPE_B:      imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            IMM_TYPE_U:      imm = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_TYPE_J:      imm = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                                    instr[20], instr[30:21], 1'b0};
            default:         imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode front end: classifies each fetched instruction, generates its immediate
// and holds the result in a 2-entry buffer with registered ready toward fetch.
module decode_imm_stage
    import decode_imm_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    decode_imm_stage_if.slave bus
);

    immediate_type_e       dec_type;
    logic                  dec_illegal;
    logic [DATA_WIDTH-1:0] gen_imm;
    buf_entry_t            new_entry;
    buf_entry_t            mem [DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [1:0]            count_next;
    logic                  ready_q;
    logic                  push;
    logic                  pop;

    // Illegal encodings always fall back to NONE so the generator yields zero.
    always_comb begin
        dec_type    = IMM_TYPE_NONE;
        dec_illegal = 1'b0;
        case (bus.in_instr_i[6:0])
            OPC_LUI, OPC_AUIPC: dec_type = IMM_TYPE_U;
            OPC_JAL:            dec_type = IMM_TYPE_J;
            OPC_JALR, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM:
                                dec_type = IMM_TYPE_I;
            OPC_STORE:          dec_type = IMM_TYPE_S;
            OPC_BRANCH:         dec_type = IMM_TYPE_B;
            OPC_OP_IMM:
                dec_type = is_shift_funct3(bus.in_instr_i[14:12]) ? IMM_TYPE_ISHIFT : IMM_TYPE_I;
            OPC_OP_IMM_32: begin
                if (!is_shift_funct3(bus.in_instr_i[14:12])) begin
                    dec_type = IMM_TYPE_I;
                end else if (bus.in_instr_i[25]) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_type = IMM_TYPE_ISHIFT;
                end
            end
            OPC_OP, OPC_OP_32:  dec_type = IMM_TYPE_NONE;
            default:            dec_illegal = 1'b1;
        endcase
    end

    immediate_generator u_immediate_generator (
        .instr    (bus.in_instr_i[INSTR_WIDTH-1:7]),
        .imm_type (dec_type),
        .imm      (gen_imm)
    );

    always_comb begin
        new_entry.instr    = bus.in_instr_i;
        new_entry.pc       = bus.in_pc_i;
        new_entry.imm      = gen_imm;
        new_entry.imm_type = dec_type;
        new_entry.illegal  = dec_illegal;
    end

    assign push = bus.in_valid_i && ready_q && !bus.flush_i;
    assign pop  = (count != 2'd0) && bus.out_ready_i;

    always_comb begin
        count_next = count;
        if (bus.flush_i) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // Ready is registered from the next occupancy so fetch never sees a comb path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_q <= 1'b1;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (push) begin
                mem[wr_ptr] <= new_entry;
            end
            if (bus.flush_i) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign bus.in_ready_o     = ready_q;
    assign bus.out_valid_o    = (count != 2'd0);
    assign bus.out_instr_o    = mem[rd_ptr].instr;
    assign bus.out_pc_o       = mem[rd_ptr].pc;
    assign bus.out_imm_o      = mem[rd_ptr].imm;
    assign bus.out_imm_type_o = mem[rd_ptr].imm_type;
    assign bus.out_illegal_o  = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: directed ISA cases plus random traffic checked
// against a queue model whose immediates come from plain ISA arithmetic.
module tb_decode_imm_stage;
    import decode_imm_stage_pkg::*;

    typedef struct {
        logic [31:0]     instr;
        logic [63:0]     pc;
        logic [63:0]     imm;
        immediate_type_e t;
        logic            ill;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    decode_imm_stage_if bus ();

    decode_imm_stage dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_instr_i  = '0;
        bus.in_pc_i     = '0;
        bus.out_ready_i = 1'b0;
    endtask

    // Reference: immediate fields assembled arithmetically from the ISA formats.
    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [63:0] pc);
        exp_t   e;
        longint s;
        longint v;
        logic   sh;
        s     = longint'($signed(ins));
        sh    = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
        e.instr = ins;
        e.pc    = pc;
        e.t     = IMM_TYPE_NONE;
        e.ill   = 1'b0;
        e.imm   = '0;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin
                e.t = IMM_TYPE_U; v = s >>> 12; e.imm = v << 12;
            end
            7'b1101111: begin
                e.t = IMM_TYPE_J; v = s >>> 31;
                e.imm = (v << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
            end
            7'b1100111, 7'b0000011, 7'b0001111, 7'b1110011: begin
                e.t = IMM_TYPE_I; v = s >>> 20; e.imm = v;
            end
            7'b0100011: begin
                e.t = IMM_TYPE_S; v = s >>> 25; e.imm = (v << 5) | 64'(ins[11:7]);
            end
            7'b1100011: begin
                e.t = IMM_TYPE_B; v = s >>> 31;
                e.imm = (v << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
            end
            7'b0010011, 7'b0011011: begin
                if (sh && ins[6:0] == 7'b0011011 && ins[25]) begin
                    e.ill = 1'b1;
                end else if (sh) begin
                    e.t = IMM_TYPE_ISHIFT; e.imm = 64'(ins[25:20]);
                end else begin
                    e.t = IMM_TYPE_I; v = s >>> 20; e.imm = v;
                end
            end
            7'b0110011, 7'b0111011: e.t = IMM_TYPE_NONE;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 14))
            0:  r[6:0] = 7'b0110111;
            1:  r[6:0] = 7'b0010111;
            2:  r[6:0] = 7'b1101111;
            3:  r[6:0] = 7'b1100111;
            4:  r[6:0] = 7'b0000011;
            5:  r[6:0] = 7'b0001111;
            6:  r[6:0] = 7'b1110011;
            7:  r[6:0] = 7'b0100011;
            8:  r[6:0] = 7'b1100011;
            9:  begin r[6:0] = 7'b0010011; if ($urandom_range(0, 1) == 1) r[13:12] = 2'b01; end
            10: begin r[6:0] = 7'b0011011; if ($urandom_range(0, 1) == 1) r[13:12] = 2'b01; end
            11: r[6:0] = 7'b0110011;
            12: r[6:0] = 7'b0111011;
            default: ;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.out_valid_o); end
        vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.in_ready_o); end
        vectors++; if (bus.out_instr_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr got=%h exp=0", bus.out_instr_o); end
        vectors++; if (bus.out_pc_o !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.out_pc_o); end
        vectors++; if (bus.out_imm_o !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_imm got=%h exp=0", bus.out_imm_o); end
        vectors++; if (bus.out_imm_type_o !== IMM_TYPE_NONE) begin miscompares++; $display("[TB] FAIL reset_type got=%0d exp=%0d", bus.out_imm_type_o, IMM_TYPE_NONE); end
        vectors++; if (bus.out_illegal_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_illegal got=%b exp=0", bus.out_illegal_o); end
    endtask

    task automatic test_addi();
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_instr_i  = 32'hFFF00093;
        bus.in_pc_i     = 64'h1000;
        tick();
        bus.in_valid_i = 1'b0;
        vectors++; if (bus.out_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL addi_valid got=%b exp=1", bus.out_valid_o); end
        vectors++; if (bus.out_imm_type_o !== IMM_TYPE_I) begin miscompares++; $display("[TB] FAIL addi_type got=%0d exp=%0d", bus.out_imm_type_o, IMM_TYPE_I); end
        vectors++; if (bus.out_imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("[TB] FAIL addi_imm got=%h exp=ffffffffffffffff", bus.out_imm_o); end
        vectors++; if (bus.out_pc_o !== 64'h1000) begin miscompares++; $display("[TB] FAIL addi_pc got=%h exp=1000", bus.out_pc_o); end
        vectors++; if (bus.out_instr_o !== 32'hFFF00093) begin miscompares++; $display("[TB] FAIL addi_instr got=%h exp=fff00093", bus.out_instr_o); end
        tick();
        vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL addi_drain got=%b exp=0", bus.out_valid_o); end
        idle();
    endtask

    task automatic test_pairs();
        logic [31:0]     ins_t [6] = '{32'h12345037, 32'h80000037, 32'hFE000EE3,
                                       32'h03F09093, 32'h0000007F, 32'h0200109B};
        logic [63:0]     imm_t [6] = '{64'h0000_0000_1234_5000, 64'hFFFF_FFFF_8000_0000,
                                       64'hFFFF_FFFF_FFFF_FFFC, 64'd63, 64'd0, 64'd0};
        immediate_type_e typ_t [6] = '{IMM_TYPE_U, IMM_TYPE_U, IMM_TYPE_B,
                                       IMM_TYPE_ISHIFT, IMM_TYPE_NONE, IMM_TYPE_NONE};
        logic            ill_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int p = 0; p < 3; p++) begin
            bus.out_ready_i = 1'b0;
            bus.in_valid_i  = 1'b1;
            for (int k = 0; k < 2; k++) begin
                bus.in_instr_i = ins_t[2*p+k];
                bus.in_pc_i    = 64'h2000 + 64'(4*(2*p+k));
                tick();
            end
            bus.in_valid_i  = 1'b0;
            bus.out_ready_i = 1'b1;
            for (int k = 0; k < 2; k++) begin
                int i = 2*p + k;
                vectors++; if (bus.out_instr_o !== ins_t[i]) begin miscompares++; $display("[TB] FAIL pair_instr[%0d] got=%h exp=%h", i, bus.out_instr_o, ins_t[i]); end
                vectors++; if (bus.out_pc_o !== 64'h2000 + 64'(4*i)) begin miscompares++; $display("[TB] FAIL pair_pc[%0d] got=%h exp=%h", i, bus.out_pc_o, 64'h2000 + 64'(4*i)); end
                vectors++; if (bus.out_imm_o !== imm_t[i]) begin miscompares++; $display("[TB] FAIL pair_imm[%0d] got=%h exp=%h", i, bus.out_imm_o, imm_t[i]); end
                vectors++; if (bus.out_imm_type_o !== typ_t[i]) begin miscompares++; $display("[TB] FAIL pair_type[%0d] got=%0d exp=%0d", i, bus.out_imm_type_o, typ_t[i]); end
                vectors++; if (bus.out_illegal_o !== ill_t[i]) begin miscompares++; $display("[TB] FAIL pair_illegal[%0d] got=%b exp=%b", i, bus.out_illegal_o, ill_t[i]); end
                tick();
            end
            vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL pair_drain[%0d] got=%b exp=0", p, bus.out_valid_o); end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_instr_i  = 32'h00500113;
        bus.in_pc_i     = 64'h3000;
        vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_a got=%b exp=1", bus.in_ready_o); end
        tick();
        bus.in_instr_i = 32'h00112223;
        bus.in_pc_i    = 64'h3004;
        vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_b got=%b exp=1", bus.in_ready_o); end
        tick();
        bus.in_instr_i = 32'h008000EF;
        bus.in_pc_i    = 64'h3008;
        vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_full got=%b exp=0", bus.in_ready_o); end
        tick();
        vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_still_full got=%b exp=0", bus.in_ready_o); end
        vectors++; if (bus.out_instr_o !== 32'h00500113) begin miscompares++; $display("[TB] FAIL bp_hold_a got=%h exp=00500113", bus.out_instr_o); end
        bus.out_ready_i = 1'b1;
        tick();
        vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_reassert got=%b exp=1", bus.in_ready_o); end
        vectors++; if (bus.out_instr_o !== 32'h00112223) begin miscompares++; $display("[TB] FAIL bp_order_b got=%h exp=00112223", bus.out_instr_o); end
        vectors++; if (bus.out_imm_o !== 64'd4) begin miscompares++; $display("[TB] FAIL bp_imm_b got=%h exp=4", bus.out_imm_o); end
        tick();
        bus.in_valid_i = 1'b0;
        vectors++; if (bus.out_instr_o !== 32'h008000EF) begin miscompares++; $display("[TB] FAIL bp_order_c got=%h exp=008000ef", bus.out_instr_o); end
        vectors++; if (bus.out_imm_o !== 64'd8) begin miscompares++; $display("[TB] FAIL bp_imm_c got=%h exp=8", bus.out_imm_o); end
        vectors++; if (bus.out_imm_type_o !== IMM_TYPE_J) begin miscompares++; $display("[TB] FAIL bp_type_c got=%0d exp=%0d", bus.out_imm_type_o, IMM_TYPE_J); end
        tick();
        vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain got=%b exp=0", bus.out_valid_o); end
        idle();
    endtask

    task automatic test_flush();
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_instr_i  = 32'h00100093;
        tick();
        bus.in_instr_i = 32'h00200093;
        tick();
        vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_prefull got=%b exp=0", bus.in_ready_o); end
        bus.flush_i    = 1'b1;
        bus.in_instr_i = 32'h00700193;
        tick();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_full_valid got=%b exp=0", bus.out_valid_o); end
        vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_full_ready got=%b exp=1", bus.in_ready_o); end
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = 32'h00100093;
        tick();
        bus.flush_i    = 1'b1;
        bus.in_instr_i = 32'h00700193;
        vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_half_ready got=%b exp=1", bus.in_ready_o); end
        tick();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drop_push got=%b exp=0", bus.out_valid_o); end
        tick();
        vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_stays_empty got=%b exp=0", bus.out_valid_o); end
        idle();
    endtask

    task automatic test_reset_midstream();
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = 32'h00100093;
        bus.in_pc_i    = 64'h4000;
        tick();
        bus.in_instr_i = 32'h00200093;
        tick();
        bus.in_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid got=%b exp=0", bus.out_valid_o); end
        vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_ready got=%b exp=1", bus.in_ready_o); end
        vectors++; if (bus.out_instr_o !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_instr got=%h exp=0", bus.out_instr_o); end
        vectors++; if (bus.out_pc_o !== 64'h0) begin miscompares++; $display("[TB] FAIL midrst_pc got=%h exp=0", bus.out_pc_o); end
        idle();
    endtask

    task automatic test_random();
        exp_t model[$];
        exp_t e;
        logic push;
        logic pop;
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            vectors++; if (bus.out_valid_o !== (model.size() != 0)) begin miscompares++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid_o, model.size() != 0); end
            vectors++; if (bus.in_ready_o !== (model.size() < 2)) begin miscompares++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready_o, model.size() < 2); end
            if (model.size() != 0) begin
                vectors++; if (bus.out_instr_o !== model[0].instr) begin miscompares++; $display("[TB] FAIL rnd_instr cyc=%0d got=%h exp=%h", cyc, bus.out_instr_o, model[0].instr); end
                vectors++; if (bus.out_pc_o !== model[0].pc) begin miscompares++; $display("[TB] FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, bus.out_pc_o, model[0].pc); end
                vectors++; if (bus.out_imm_o !== model[0].imm) begin miscompares++; $display("[TB] FAIL rnd_imm cyc=%0d instr=%h got=%h exp=%h", cyc, model[0].instr, bus.out_imm_o, model[0].imm); end
                vectors++; if (bus.out_imm_type_o !== model[0].t) begin miscompares++; $display("[TB] FAIL rnd_type cyc=%0d instr=%h got=%0d exp=%0d", cyc, model[0].instr, bus.out_imm_type_o, model[0].t); end
                vectors++; if (bus.out_illegal_o !== model[0].ill) begin miscompares++; $display("[TB] FAIL rnd_illegal cyc=%0d instr=%h got=%b exp=%b", cyc, model[0].instr, bus.out_illegal_o, model[0].ill); end
            end
            bus.in_valid_i  = ($urandom_range(0, 3) != 0);
            bus.in_instr_i  = rand_instr();
            bus.in_pc_i     = {$urandom, $urandom} & ~64'h3;
            bus.out_ready_i = ((cyc % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.flush_i     = ($urandom_range(0, 19) == 0);
            push = bus.in_valid_i && (model.size() < 2) && !bus.flush_i;
            pop  = (model.size() != 0) && bus.out_ready_i;
            e    = ref_entry(bus.in_instr_i, bus.in_pc_i);
            tick();
            if (bus.flush_i) begin
                model.delete();
            end else begin
                if (pop)  void'(model.pop_front());
                if (push) model.push_back(e);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk_i);
        $display("[TB] starting decode_imm_stage bench");
        test_reset();
        test_addi();
        test_pairs();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
